// File: rtl/al_buckeye_readback_pkg.sv
// Constants and state encoding shared by the Buckeye chain controllers.
package al_buckeye_readback_pkg;

    localparam int CHAIN_BITS    = 288;
    localparam int BKY_PER_CHAIN = 6;
    localparam int BITS_PER_BKY  = 48;
    localparam int SHCK_DIV      = 40;
    localparam int SETUP_CYCLES  = 8;
    localparam int WORD_BITS     = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_STALL = 3'd3,
        ST_TAIL  = 3'd4,
        ST_FIN   = 3'd5
    } bky_state_t;

    // Index width that stays legal when the chain holds a single word.
    function automatic int idx_width(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/al_buckeye_readback_bky_shck_gen.sv
// Shift-clock generator: one bit per DIV-cycle period, low half then high half.
// The sample strobe fires two cycles before the rise so the registered data
// is already stable during the last low cycle.
module bky_shck_gen #(
    parameter int DIV = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic stall,
    output logic shck,
    output logic sample_stb,
    output logic rise_stb,
    output logic period_end
);

    localparam int PW   = $clog2(DIV);
    localparam int HALF = DIV / 2;
    localparam logic [PW-1:0] PH_LOAD   = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(HALF + 1);
    localparam logic [PW-1:0] PH_RISE   = PW'(HALF);

    logic [PW-1:0] ph_q;
    logic [PW-1:0] ph_nxt;
    logic          adv;

    assign adv        = run && !stall;
    assign sample_stb = adv && (ph_q == PH_SAMPLE);
    assign rise_stb   = adv && (ph_q == PH_RISE);
    assign period_end = adv && (ph_q == '0);

    // Down-counter reloads at terminal count; parked at reload value when idle.
    always_comb begin
        ph_nxt = PH_LOAD;
        if (adv && (ph_q != '0))
            ph_nxt = ph_q - 1'b1;
    end

    // SHCK is registered from the next phase so it stays glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q <= PH_LOAD;
            shck <= 1'b0;
        end else begin
            ph_q <= ph_nxt;
            shck <= adv && (ph_nxt < PH_RISE);
        end
    end

endmodule

// File: rtl/al_buckeye_readback.sv
// Non-destructive Buckeye chain readback: clocks the chain once, recirculates
// every returned bit and hands the bits out as 16-bit words.
//
// state | meaning
// IDLE  | chain mux released, waiting for START
// SETUP | mux owned, SHCK low for SETUP_CYC cycles
// SHIFT | clocking bits, sampling SDATA_RTN
// STALL | word pending behind a full holding register, SHCK low
// TAIL  | all bits clocked, SHCK low, waiting for last ack
// FIN   | complete, DONE set, mux released
module al_buckeye_readback
    import al_buckeye_readback_pkg::*;
#(
    parameter  int NBITS     = CHAIN_BITS,
    parameter  int DIV       = SHCK_DIV,
    parameter  int SETUP_CYC = SETUP_CYCLES,
    localparam int NWORDS    = NBITS / WORD_BITS,
    localparam int IW        = idx_width(NWORDS)
) (
    input  logic          CLK40,
    input  logic          RST_N,
    input  logic          START,
    input  logic          CLR_DONE,
    input  logic          SDATA_RTN,
    input  logic          WORD_ACK,
    output logic          BKY_ENA,
    output logic          SHCK,
    output logic          SDATA,
    output logic [15:0]   WORD_DATA,
    output logic          WORD_VLD,
    output logic [IW-1:0] WORD_IDX,
    output logic          BUSY,
    output logic          DONE
);

    localparam int BW   = $clog2(NBITS + 1);
    localparam int TMAX = (SETUP_CYC > DIV / 2) ? SETUP_CYC : DIV / 2;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS);
    localparam logic [TW-1:0] TMR_SETUP = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] TMR_TAIL  = TW'(DIV / 2 - 1);

    bky_state_t    state_q, state_nxt;
    logic [TW-1:0] tmr_q;
    logic [BW-1:0] bit_cnt_q;
    logic [3:0]    wbit_q;
    logic [15:0]   sreg_q;
    logic          word_full_q;
    logic [IW-1:0] next_idx_q;
    logic          busy_q, done_q, vld_q, sdata_q;
    logic [15:0]   data_q;
    logic [IW-1:0] idx_q;
    logic          shck_w, sample_stb, rise_stb, period_end;
    logic          start_go, fin_go, busy_nxt;
    logic          can_take, word_done, all_bits;
    logic [15:0]   word_new;

    assign can_take  = !vld_q || WORD_ACK;
    assign word_new  = {sreg_q[14:0], SDATA_RTN};
    assign word_done = sample_stb && (wbit_q == 4'hF);
    assign all_bits  = (bit_cnt_q == BIT_LAST);

    assign BKY_ENA   = busy_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign SHCK      = shck_w;
    assign SDATA     = sdata_q;
    assign WORD_DATA = data_q;
    assign WORD_VLD  = vld_q;
    assign WORD_IDX  = idx_q;

    bky_shck_gen #(.DIV(DIV)) u_shck (
        .clk        (CLK40),
        .rst_n      (RST_N),
        .run        ((state_q == ST_SHIFT) || (state_q == ST_STALL)),
        .stall      (state_q == ST_STALL),
        .shck       (shck_w),
        .sample_stb (sample_stb),
        .rise_stb   (rise_stb),
        .period_end (period_end)
    );

    // State register.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // Next-state decode; stalls and the tail are only entered at a period end.
    always_comb begin
        state_nxt = state_q;
        start_go  = 1'b0;
        fin_go    = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (START) begin
                    state_nxt = ST_SETUP;
                    start_go  = 1'b1;
                end
            end
            ST_SETUP: if (tmr_q == '0) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (period_end) begin
                    if (word_full_q && !can_take) state_nxt = ST_STALL;
                    else if (all_bits)            state_nxt = ST_TAIL;
                end
            end
            ST_STALL: if (can_take) state_nxt = all_bits ? ST_TAIL : ST_SHIFT;
            ST_TAIL: begin
                if ((tmr_q == '0) && can_take) begin
                    state_nxt = ST_FIN;
                    fin_go    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_FIN);
    end

    // Mux ownership/busy and the sticky done flag; START beats CLR_DONE.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            if (fin_go)                   done_q <= 1'b1;
            else if (CLR_DONE || start_go) done_q <= 1'b0;
        end
    end

    // Setup/tail down-counter, loaded on state entry, held at terminal count.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N)
            tmr_q <= '0;
        else if (start_go)
            tmr_q <= TMR_SETUP;
        else if ((state_q != ST_TAIL) && (state_nxt == ST_TAIL))
            tmr_q <= TMR_TAIL;
        else if (tmr_q != '0)
            tmr_q <= tmr_q - 1'b1;
    end

    // Sampling, word packing and the holding register handshake.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt_q   <= '0;
            wbit_q      <= '0;
            sreg_q      <= '0;
            word_full_q <= 1'b0;
            next_idx_q  <= '0;
            sdata_q     <= 1'b0;
            data_q      <= '0;
            idx_q       <= '0;
            vld_q       <= 1'b0;
        end else if (start_go) begin
            bit_cnt_q   <= '0;
            wbit_q      <= '0;
            sreg_q      <= '0;
            word_full_q <= 1'b0;
            next_idx_q  <= '0;
        end else begin
            if (rise_stb)
                bit_cnt_q <= bit_cnt_q + 1'b1;
            if (sample_stb) begin
                sdata_q <= SDATA_RTN;
                sreg_q  <= word_new;
                wbit_q  <= wbit_q + 1'b1;
            end
            if ((word_done || word_full_q) && can_take) begin
                data_q      <= word_done ? word_new : sreg_q;
                idx_q       <= next_idx_q;
                next_idx_q  <= next_idx_q + 1'b1;
                vld_q       <= 1'b1;
                word_full_q <= 1'b0;
            end else begin
                if (vld_q && WORD_ACK) vld_q <= 1'b0;
                if (word_done)         word_full_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_al_buckeye_readback.sv
// Bench for al_buckeye_readback: 48-bit chain model, DIV=4, SETUP_CYC=8.
module tb_al_buckeye_readback;

    localparam int NB = 48;
    localparam int DV = 4;
    localparam int SC = 8;
    localparam int NW = NB / 16;
    localparam int IW = 2;
    localparam int CLKP = 10;
    localparam int RUN_LIMIT = 3000;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr_done = 1'b0, word_ack = 1'b0;
    logic sdata_rtn, bky_ena, shck, sdata, word_vld, busy, done;
    logic [15:0]   word_data;
    logic [IW-1:0] word_idx;

    int checks = 0;
    int errors = 0;

    always #(CLKP/2) clk = ~clk;

    al_buckeye_readback #(.NBITS(NB), .DIV(DV), .SETUP_CYC(SC)) dut (
        .CLK40(clk), .RST_N(rst_n), .START(start), .CLR_DONE(clr_done),
        .SDATA_RTN(sdata_rtn), .WORD_ACK(word_ack), .BKY_ENA(bky_ena),
        .SHCK(shck), .SDATA(sdata), .WORD_DATA(word_data), .WORD_VLD(word_vld),
        .WORD_IDX(word_idx), .BUSY(busy), .DONE(done)
    );

    // Behavioural chain: the last stage drives SDATA_RTN, SHCK rise shifts SDATA in.
    logic [NB-1:0] chain, preload_val;
    logic preload = 1'b0;
    int   rise_cnt = 0;
    int   viol_pre = 0, viol_post = 0;
    time  t_rise = 0, t_sd = 0;

    assign sdata_rtn = chain[NB-1];

    always @(posedge shck or posedge preload) begin
        if (preload) chain <= preload_val;
        else begin
            chain    <= {chain[NB-2:0], sdata};
            rise_cnt <= rise_cnt + 1;
            if (bky_ena && ($time - t_sd < CLKP)) viol_pre <= viol_pre + 1;
            t_rise <= $time;
        end
    end

    always @(sdata) begin
        if (bky_ena === 1'b1 && rise_cnt > 0 && ($time - t_rise < (DV/2)*CLKP))
            viol_post = viol_post + 1;
        t_sd = $time;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full readback of pattern pat; words must equal exp_words MSB-first.
    task automatic run_rb(input logic [NB-1:0] pat, input logic [NB-1:0] exp_words,
                          input int hold0, input bit rnd, input bit poke, input bit with_clr);
        int got, wait_c, delay, cyc, c_rise, r0, vpre0, vpost0, stall_bad;
        preload_val = pat;
        preload = 1'b1; #1; preload = 1'b0;
        @(negedge clk);
        if (with_clr) chk("done_before_start", done, 1);
        start = 1'b1; clr_done = with_clr;
        @(negedge clk);
        start = 1'b0; clr_done = 1'b0;
        chk("ena_after_start", bky_ena, 1);
        if (with_clr) begin
            chk("done_cleared_by_start", done, 0);
            chk("busy_after_start_clr", busy, 1);
        end
        r0 = rise_cnt; vpre0 = viol_pre; vpost0 = viol_post;
        got = 0; wait_c = 0; delay = hold0; cyc = 0; c_rise = -1; stall_bad = 0;
        while (!done && cyc < RUN_LIMIT) begin
            if (shck && c_rise < 0) c_rise = cyc;
            start = (poke && cyc == 60);
            if (word_vld) begin
                if (wait_c >= delay) begin
                    if (got < NW) begin
                        chk("word_data", word_data, exp_words[16*(NW-1-got) +: 16]);
                        chk("word_idx", word_idx, got);
                    end else chk("extra_word", got, NW - 1);
                    got++;
                    word_ack = 1'b1; wait_c = 0;
                    delay = rnd ? int'($urandom_range(0, 80)) : 0;
                end else begin
                    word_ack = 1'b0; wait_c++;
                    if (hold0 >= 100 && got == 0 && wait_c > hold0 - 20 && shck !== 1'b0)
                        stall_bad++;
                end
            end else begin
                word_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        word_ack = 1'b0; start = 1'b0;
        chk("run_timeout", cyc < RUN_LIMIT, 1);
        chk("word_count", got, NW);
        chk("shck_rises", rise_cnt - r0, NB);
        chk("chain_restored", chain, pat);
        chk("done_end", done, 1);
        chk("ena_end", bky_ena, 0);
        chk("busy_end", busy, 0);
        chk("vld_end", word_vld, 0);
        chk("setup_gap", c_rise, SC + DV/2);
        chk("sdata_setup_viol", viol_pre - vpre0, 0);
        chk("sdata_hold_viol", viol_post - vpost0, 0);
        if (hold0 >= 100) chk("shck_during_stall", stall_bad, 0);
    endtask

    typedef struct {
        logic [NB-1:0] pat;
        int            hold0;
        logic [NB-1:0] words;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [NB-1:0] rpat, snap;
        int r0, n;

        vecs[0] = '{48'h1234_5678_9ABC, 0,   {16'h1234, 16'h5678, 16'h9ABC}};
        vecs[1] = '{48'h8001_A5C3_7E18, 0,   {16'h8001, 16'hA5C3, 16'h7E18}};
        vecs[2] = '{48'h1234_5678_9ABC, 120, {16'h1234, 16'h5678, 16'h9ABC}};
        vecs[3] = '{48'hFFFF_0000_FFFF, 0,   {16'hFFFF, 16'h0000, 16'hFFFF}};
        vecs[4] = '{48'h0000_0000_0001, 120, {16'h0000, 16'h0000, 16'h0001}};

        repeat (3) @(negedge clk);
        chk("rst_shck", shck, 0);
        chk("rst_ena", bky_ena, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vld", word_vld, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_data", word_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_rb(vecs[i].pat, vecs[i].words, vecs[i].hold0, 1'b0, 1'b0, 1'b0);

        // Random chains, random ack latency, stray acks while nothing is valid.
        for (int i = 0; i < 4; i++) begin
            rpat = NB'({$urandom(), $urandom()});
            run_rb(rpat, rpat, int'($urandom_range(0, 130)), 1'b1, 1'b0, 1'b0);
        end

        // START mid-run is ignored.
        run_rb(48'hC3C3_5A5A_0F0F, 48'hC3C3_5A5A_0F0F, 0, 1'b0, 1'b1, 1'b0);

        // START together with CLR_DONE from DONE=1 starts a new run.
        run_rb(48'h0F0F_F0F0_3C3C, 48'h0F0F_F0F0_3C3C, 0, 1'b0, 1'b0, 1'b1);

        // CLR_DONE alone clears DONE.
        @(negedge clk); clr_done = 1'b1;
        @(negedge clk); clr_done = 1'b0;
        chk("clr_done_alone", done, 0);
        chk("clr_done_busy", busy, 0);

        // Reset during the high phase of the 10th bit.
        preload_val = 48'hDEAD_BEEF_0123;
        preload = 1'b1; #1; preload = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        r0 = rise_cnt; n = 0;
        while (rise_cnt - r0 < 10 && n < 500) begin
            @(negedge clk); n++;
        end
        chk("rst_wait_timeout", n < 500, 1);
        chk("rst_shck_high_before", shck, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_shck", shck, 0);
        chk("midrst_ena", bky_ena, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_vld", word_vld, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        snap = chain;
        run_rb(snap, snap, 0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
